// File: rtl/upg_load_ctrl.sv
// UART program-download controller: debounces the load button, holds the CPU
// in reset while routing UART writes to instruction/data memory, then drains.
module upg_load_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned DRAIN_CYCLES    = 16,
    parameter int unsigned IDLE_TIMEOUT    = 10000000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        start_pg,
    input  logic        upg_wen_i,
    input  logic [14:0] upg_adr_i,
    input  logic        upg_done_i,
    output logic        upg_rst_o,
    output logic        cpu_rst_o,
    output logic        imem_wen_o,
    output logic        dmem_wen_o,
    output logic [13:0] mem_adr_o,
    output logic [15:0] word_cnt_o,
    output logic        load_err_o,
    output logic [1:0]  state_o
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DR_W = (DRAIN_CYCLES < 2)    ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned TO_W = (IDLE_TIMEOUT < 2)    ? 1 : $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_press;
    logic [DR_W-1:0]   r_drain_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_first_seen;
    logic              r_upg_rst;
    logic [15:0]       r_word_cnt;
    logic              r_load_err;
    logic              w_in_load;

    // Two-flop synchroniser for the asynchronous pushbutton
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= start_pg;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: count while held, saturate so a long press yields one pulse
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_press <= r_sync2 && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
            if (!r_sync2) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt != DB_W'(DEBOUNCE_CYCLES)) begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Mode sequencer RUN -> LOAD -> DRAIN -> RUN with load bookkeeping
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_upg_rst    <= 1'b1;
            r_word_cnt   <= '0;
            r_load_err   <= 1'b0;
            r_to_cnt     <= '0;
            r_first_seen <= 1'b0;
            r_drain_cnt  <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_upg_rst <= 1'b1;
                    if (r_press) begin
                        r_state      <= ST_LOAD;
                        r_upg_rst    <= 1'b0;
                        r_word_cnt   <= '0;
                        r_load_err   <= 1'b0;
                        r_to_cnt     <= '0;
                        r_first_seen <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (upg_wen_i) begin
                        r_first_seen <= 1'b1;
                        r_to_cnt     <= '0;
                        if (r_word_cnt != 16'hFFFF) begin
                            r_word_cnt <= r_word_cnt + 16'd1;
                        end
                    end else if (r_first_seen) begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                    // Done wins over a coincident timeout: the download completed
                    if (upg_done_i) begin
                        r_state     <= ST_DRAIN;
                        r_upg_rst   <= 1'b1;
                        r_drain_cnt <= '0;
                    end else if (!upg_wen_i && r_first_seen &&
                                 (r_to_cnt == TO_W'(IDLE_TIMEOUT - 1))) begin
                        r_state     <= ST_DRAIN;
                        r_upg_rst   <= 1'b1;
                        r_load_err  <= 1'b1;
                        r_drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    r_upg_rst <= 1'b1;
                    if (r_drain_cnt == DR_W'(DRAIN_CYCLES - 1)) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DR_W'(1);
                    end
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_upg_rst <= 1'b1;
                end
            endcase
        end
    end

    // Zero-latency write routing, gated to LOAD only
    always_comb begin
        w_in_load  = (r_state == ST_LOAD);
        imem_wen_o = w_in_load && upg_wen_i && !upg_adr_i[14];
        dmem_wen_o = w_in_load && upg_wen_i &&  upg_adr_i[14];
        cpu_rst_o  = rst || (r_state != ST_RUN);
    end

    assign mem_adr_o  = upg_adr_i[13:0];
    assign upg_rst_o  = r_upg_rst;
    assign word_cnt_o = r_word_cnt;
    assign load_err_o = r_load_err;
    assign state_o    = r_state;

endmodule
